// File: rtl/ctrl_vic_if.sv
// Pipeline-facing bundle of ctrl_vic: IRQ lines, commit-point strobes, CR read port and redirect.
// Pure wiring; timing belongs to ctrl_vic, and there is no handshake to stall on.
interface ctrl_vic_if #(
   parameter int IRQ_CH = 8,
   parameter int ADDR_W = 30
);
   logic [IRQ_CH-1:0] irq;
   logic              commit_en;
   logic [ADDR_W-1:0] commit_pc;
   logic [2:0]        exc_code;
   logic              exrt;
   logic              wrcr;
   logic [4:0]        cr_addr;
   logic [31:0]       cr_wdata;
   logic [4:0]        creg_rd_addr;
   logic [31:0]       creg_rd_data;
   logic              exe_mode;
   logic              int_detect;
   logic [3:0]        int_id;
   logic [ADDR_W-1:0] new_pc;
   logic              flush;

   modport master (
      output irq, commit_en, commit_pc, exc_code, exrt, wrcr, cr_addr, cr_wdata, creg_rd_addr,
      input  creg_rd_data, exe_mode, int_detect, int_id, new_pc, flush
   );

   modport slave (
      input  irq, commit_en, commit_pc, exc_code, exrt, wrcr, cr_addr, cr_wdata, creg_rd_addr,
      output creg_rd_data, exe_mode, int_detect, int_id, new_pc, flush
   );
endinterface

// File: rtl/ctrl_vic.sv
// Control registers, exception / vectored-IRQ / EXRT / WRCR arbitration with a nesting context stack.
// Redirect (new_pc/flush) is combinational with commit_en; state lands on the next edge; never stalls.
module ctrl_vic #(
   parameter int IRQ_CH     = 8,
   parameter int ADDR_W     = 30,
   parameter int NEST_DEPTH = 4,
   parameter int VEC_STRIDE = 4
) (
   input logic       clk,
   input logic       reset,
   ctrl_vic_if.slave bus
);
   localparam int LVL_W = $clog2(NEST_DEPTH + 1);

   typedef struct packed {
      logic              exe_mode;
      logic              int_en;
      logic [ADDR_W-1:0] epc;
   } ctx_t;

   logic              exe_mode_q, exe_mode_d;
   logic              int_en_q, int_en_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [8:0]        cause_q, cause_d;
   logic [IRQ_CH-1:0] mask_q, mask_d;
   logic [IRQ_CH-1:0] mode_q, mode_d;
   logic [IRQ_CH-1:0] lat_q, lat_d;
   logic [IRQ_CH-1:0] irq_prev_q, irq_prev_d;
   logic [LVL_W-1:0]  nest_lvl_q, nest_lvl_d;
   ctx_t              stack_q [NEST_DEPTH];
   ctx_t              stack_d [NEST_DEPTH];

   logic [IRQ_CH-1:0] pending, eligible, lat_clr;
   logic [3:0]        int_id;
   logic              int_detect, stack_full;
   logic              take_exc, take_irq, take_exrt, take_wrcr;
   logic [ADDR_W-1:0] vec_off, new_pc;
   logic [31:0]       rd_data;
   ctx_t              pop_ctx;

   always_comb begin
      pending  = (mode_q & lat_q) | (~mode_q & bus.irq);
      eligible = pending & ~mask_q;
      int_id   = '0;
      for (int i = IRQ_CH - 1; i >= 0; i--) begin
         if (eligible[i]) int_id = 4'(i);
      end
      stack_full = (nest_lvl_q == LVL_W'(NEST_DEPTH));
      int_detect = int_en_q & (|eligible) & ~stack_full;

      take_exc  = bus.commit_en & (bus.exc_code != 3'd0);
      take_irq  = bus.commit_en & ~take_exc & int_detect;
      take_exrt = bus.commit_en & ~take_exc & ~take_irq & bus.exrt;
      take_wrcr = bus.commit_en & ~take_exc & ~take_irq & ~bus.exrt & bus.wrcr;

      vec_off = ADDR_W'(({28'd0, int_id} + 32'd1) * 32'(VEC_STRIDE));
      new_pc  = '0;
      if (take_exc)       new_pc = base_q;
      else if (take_irq)  new_pc = base_q + vec_off;
      else if (take_exrt) new_pc = epc_q;
      else if (take_wrcr) new_pc = bus.commit_pc + ADDR_W'(1);

      // An empty stack pops to kernel mode with interrupts off and epc kept.
      pop_ctx = '{exe_mode: 1'b0, int_en: 1'b0, epc: epc_q};
      for (int i = 0; i < NEST_DEPTH; i++) begin
         if (nest_lvl_q == LVL_W'(i + 1)) pop_ctx = stack_q[i];
      end
   end

   always_comb begin
      exe_mode_d = exe_mode_q;
      int_en_d   = int_en_q;
      epc_d      = epc_q;
      base_d     = base_q;
      cause_d    = cause_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      nest_lvl_d = nest_lvl_q;
      stack_d    = stack_q;
      lat_clr    = '0;
      irq_prev_d = bus.irq;

      if (take_exc || take_irq) begin
         if (!stack_full) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
               if (nest_lvl_q == LVL_W'(i)) stack_d[i] = '{exe_mode: exe_mode_q, int_en: int_en_q, epc: epc_q};
            end
            nest_lvl_d = nest_lvl_q + LVL_W'(1);
         end else begin
            cause_d[8] = 1'b1;
         end
         epc_d        = bus.commit_pc;
         exe_mode_d   = 1'b0;
         int_en_d     = 1'b0;
         cause_d[7:0] = take_exc ? {5'd0, bus.exc_code} : {int_id, 4'b1000};
         if (take_irq) begin
            for (int i = 0; i < IRQ_CH; i++) begin
               if (int_id == 4'(i)) lat_clr[i] = 1'b1;
            end
         end
      end else if (take_exrt) begin
         exe_mode_d = pop_ctx.exe_mode;
         int_en_d   = pop_ctx.int_en;
         epc_d      = pop_ctx.epc;
         if (nest_lvl_q != '0) nest_lvl_d = nest_lvl_q - LVL_W'(1);
      end else if (take_wrcr) begin
         case (bus.cr_addr)
            5'd0: begin
               exe_mode_d = bus.cr_wdata[0];
               int_en_d   = bus.cr_wdata[1];
            end
            5'd3: epc_d   = bus.cr_wdata[ADDR_W+1:2];
            5'd4: base_d  = bus.cr_wdata[ADDR_W+1:2];
            5'd5: cause_d = bus.cr_wdata[8:0];
            5'd6: mask_d  = bus.cr_wdata[IRQ_CH-1:0];
            5'd7: lat_clr = bus.cr_wdata[IRQ_CH-1:0];
            5'd8: mode_d  = bus.cr_wdata[IRQ_CH-1:0];
            default: ;
         endcase
      end

      // A new rising edge in the same cycle as a clear keeps the latch set.
      lat_d = (lat_q & ~lat_clr) | (bus.irq & ~irq_prev_q & mode_q);
   end

   always_comb begin
      case (bus.creg_rd_addr)
         5'd0:    rd_data = {30'd0, int_en_q, exe_mode_q};
         5'd3:    rd_data = 32'({epc_q, 2'b00});
         5'd4:    rd_data = 32'({base_q, 2'b00});
         5'd5:    rd_data = 32'(cause_q);
         5'd6:    rd_data = 32'(mask_q);
         5'd7:    rd_data = 32'(pending);
         5'd8:    rd_data = 32'(mode_q);
         5'd9:    rd_data = 32'(nest_lvl_q);
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exe_mode_q <= 1'b0;
         int_en_q   <= 1'b0;
         epc_q      <= '0;
         base_q     <= '0;
         cause_q    <= '0;
         mask_q     <= '1;
         mode_q     <= '0;
         lat_q      <= '0;
         irq_prev_q <= '0;
         nest_lvl_q <= '0;
         for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         exe_mode_q <= exe_mode_d;
         int_en_q   <= int_en_d;
         epc_q      <= epc_d;
         base_q     <= base_d;
         cause_q    <= cause_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         lat_q      <= lat_d;
         irq_prev_q <= irq_prev_d;
         nest_lvl_q <= nest_lvl_d;
         stack_q    <= stack_d;
      end
   end

   assign bus.creg_rd_data = rd_data;
   assign bus.exe_mode     = exe_mode_q;
   assign bus.int_detect   = int_detect;
   assign bus.int_id       = int_id;
   assign bus.new_pc       = new_pc;
   assign bus.flush        = take_exc | take_irq | take_exrt | take_wrcr;
endmodule

// File: tb/tb_ctrl_vic.sv
// Bench for ctrl_vic: directed scenarios plus randomized commits against a queue-based reference model.
module tb_ctrl_vic;
   localparam int IRQ_CH = 8;
   localparam int ADDR_W = 30;
   localparam int DEPTH  = 2;
   localparam int STRIDE = 4;

   logic clk = 1'b0;
   logic reset;
   ctrl_vic_if #(.IRQ_CH(IRQ_CH), .ADDR_W(ADDR_W)) bus ();

   ctrl_vic #(.IRQ_CH(IRQ_CH), .ADDR_W(ADDR_W), .NEST_DEPTH(DEPTH), .VEC_STRIDE(STRIDE)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model state; the context stack is a plain queue of {exe_mode, int_en, epc}.
   bit        m_exe, m_ie;
   bit [29:0] m_epc, m_base;
   bit [8:0]  m_cause;
   bit [7:0]  m_mask, m_mode, m_lat, m_prev;
   bit [31:0] m_stk[$];

   task automatic m_reset();
      m_exe = 0; m_ie = 0; m_epc = '0; m_base = '0; m_cause = '0;
      m_mask = 8'hFF; m_mode = '0; m_lat = '0; m_prev = '0;
      m_stk.delete();
   endtask

   function automatic bit [7:0] m_pending();
      bit [7:0] p;
      for (int i = 0; i < 8; i++) p[i] = m_mode[i] ? m_lat[i] : bus.irq[i];
      return p;
   endfunction

   function automatic int m_lowest(input bit [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a);
      case (a)
         5'd0: return {30'd0, m_ie, m_exe};
         5'd3: return {m_epc, 2'b00};
         5'd4: return {m_base, 2'b00};
         5'd5: return {23'd0, m_cause};
         5'd6: return {24'd0, m_mask};
         5'd7: return {24'd0, m_pending()};
         5'd8: return {24'd0, m_mode};
         5'd9: return m_stk.size();
         default: return 0;
      endcase
   endfunction

   // One clock: check outputs against the model, then advance the model across the edge.
   task automatic cycle();
      bit [7:0]  elig, clr, set;
      bit [29:0] xpc;
      bit [31:0] top;
      bit        det;
      int        id, kind;
      #1;
      elig = m_pending() & ~m_mask;
      id   = m_lowest(elig);
      det  = m_ie && (elig != 0) && (m_stk.size() < DEPTH);
      kind = 0;
      if (bus.commit_en) begin
         if (bus.exc_code != 0) kind = 1;
         else if (det)          kind = 2;
         else if (bus.exrt)     kind = 3;
         else if (bus.wrcr)     kind = 4;
      end
      case (kind)
         1: xpc = m_base;
         2: xpc = m_base + 30'((id + 1) * STRIDE);
         3: xpc = m_epc;
         4: xpc = bus.commit_pc + 30'd1;
         default: xpc = '0;
      endcase
      check_val("flush", bus.flush, kind != 0);
      check_val("new_pc", 32'(bus.new_pc), 32'(xpc));
      check_val("int_detect", bus.int_detect, det);
      check_val("int_id", bus.int_id, id);
      check_val("exe_mode", bus.exe_mode, m_exe);
      check_val("creg_rd", bus.creg_rd_data, m_read(bus.creg_rd_addr));
      @(posedge clk);
      if (!reset) begin
         set = bus.irq & ~m_prev & m_mode;
         clr = '0;
         if (kind == 1 || kind == 2) begin
            if (m_stk.size() < DEPTH) m_stk.push_back({m_exe, m_ie, m_epc});
            else m_cause[8] = 1'b1;
            m_epc = bus.commit_pc; m_exe = 0; m_ie = 0;
            m_cause[7:0] = (kind == 1) ? {5'd0, bus.exc_code} : {id[3:0], 4'b1000};
            if (kind == 2) clr[id] = 1'b1;
         end else if (kind == 3) begin
            if (m_stk.size() > 0) begin
               top = m_stk.pop_back();
               m_exe = top[31]; m_ie = top[30]; m_epc = top[29:0];
            end else begin
               m_exe = 0; m_ie = 0;
            end
         end else if (kind == 4) begin
            case (bus.cr_addr)
               5'd0: begin m_exe = bus.cr_wdata[0]; m_ie = bus.cr_wdata[1]; end
               5'd3: m_epc   = bus.cr_wdata[31:2];
               5'd4: m_base  = bus.cr_wdata[31:2];
               5'd5: m_cause = bus.cr_wdata[8:0];
               5'd6: m_mask  = bus.cr_wdata[7:0];
               5'd7: clr     = bus.cr_wdata[7:0];
               5'd8: m_mode  = bus.cr_wdata[7:0];
               default: ;
            endcase
         end
         m_lat  = (m_lat & ~clr) | set;
         m_prev = bus.irq;
      end
      @(negedge clk);
   endtask

   task automatic set_in(input bit ce, input bit [29:0] pc, input bit [2:0] exc, input bit ex,
                         input bit wr, input bit [4:0] a, input bit [31:0] d);
      bus.commit_en = ce; bus.commit_pc = pc; bus.exc_code = exc;
      bus.exrt = ex; bus.wrcr = wr; bus.cr_addr = a; bus.cr_wdata = d;
   endtask

   task automatic wr_cr(input bit [29:0] pc, input bit [4:0] a, input bit [31:0] d);
      set_in(1, pc, 0, 0, 1, a, d);
      cycle();
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0);
      cycle();
   endtask

   task automatic rd_chk(input string tag, input bit [4:0] a, input bit [31:0] exp);
      set_in(0, 0, 0, 0, 0, 0, 0);
      bus.creg_rd_addr = a;
      #1;
      check_val(tag, bus.creg_rd_data, exp);
      cycle();
   endtask

   initial begin
      reset = 1'b1;
      bus.irq = '0;
      bus.creg_rd_addr = 5'd6;
      set_in(0, 0, 0, 0, 0, 0, 0);
      m_reset();
      #1;
      check_val("rst_mask", bus.creg_rd_data, 32'hFF);
      check_val("rst_flush", bus.flush, 0);
      check_val("rst_exe", bus.exe_mode, 0);
      @(negedge clk);
      reset = 1'b0;

      // Edge IRQ dispatch on channel 2.
      wr_cr(30'h200, 5'd4, 32'h400);
      wr_cr(30'h201, 5'd8, 32'h04);
      wr_cr(30'h202, 5'd6, 32'h00);
      wr_cr(30'h203, 5'd0, 32'h02);
      bus.irq = 8'h04;
      idle();
      bus.irq = 8'h00;
      set_in(1, 30'h40, 0, 0, 0, 0, 0);
      #1;
      check_val("edge_flush", bus.flush, 1);
      check_val("edge_new_pc", 32'(bus.new_pc), 32'h10C);
      check_val("edge_int_id", bus.int_id, 2);
      cycle();
      rd_chk("edge_epc", 5'd3, 32'h100);
      rd_chk("edge_cause", 5'd5, 32'h28);
      rd_chk("edge_pend", 5'd7, 32'h0);
      rd_chk("edge_lvl", 5'd9, 32'h1);
      set_in(1, 30'h10C, 0, 1, 0, 0, 0);
      #1;
      check_val("edge_ret_pc", 32'(bus.new_pc), 32'h40);
      cycle();

      // Nesting to full depth on level channel 6, then unwinding.
      wr_cr(30'h300, 5'd0, 32'h03);
      bus.irq = 8'h40;
      set_in(1, 30'h10, 0, 0, 0, 0, 0);
      #1;
      check_val("nest1_pc", 32'(bus.new_pc), 32'h11C);
      cycle();
      wr_cr(30'h11C, 5'd0, 32'h02);
      set_in(1, 30'h20, 0, 0, 0, 0, 0);
      #1;
      check_val("nest2_pc", 32'(bus.new_pc), 32'h11C);
      cycle();
      wr_cr(30'h11C, 5'd0, 32'h02);
      set_in(0, 0, 0, 0, 0, 0, 0);
      bus.creg_rd_addr = 5'd9;
      #1;
      check_val("full_no_detect", bus.int_detect, 0);
      check_val("full_lvl", bus.creg_rd_data, 2);
      cycle();
      bus.irq = 8'h00;
      set_in(1, 30'h120, 0, 1, 0, 0, 0);
      #1;
      check_val("exrt1_pc", 32'(bus.new_pc), 32'h20);
      cycle();
      set_in(1, 30'h121, 0, 1, 0, 0, 0);
      #1;
      check_val("exrt2_pc", 32'(bus.new_pc), 32'h10);
      cycle();
      check_val("restored_exe", bus.exe_mode, 1);
      rd_chk("restored_status", 5'd0, 32'h3);

      // Exception with a full stack overwrites the current context.
      set_in(1, 30'h50, 3'd2, 0, 0, 0, 0); cycle();
      set_in(1, 30'h60, 3'd2, 0, 0, 0, 0); cycle();
      set_in(1, 30'h30, 3'd1, 0, 0, 0, 0);
      #1;
      check_val("ovf_pc", 32'(bus.new_pc), 32'h100);
      cycle();
      rd_chk("ovf_lvl", 5'd9, 32'h2);
      rd_chk("ovf_epc", 5'd3, 32'hC0);
      rd_chk("ovf_cause", 5'd5, 32'h101);
      set_in(1, 30'h70, 0, 1, 0, 0, 0); cycle();
      set_in(1, 30'h71, 0, 1, 0, 0, 0); cycle();

      // Exception outranks a pending interrupt; level lines stay pending.
      wr_cr(30'h400, 5'd0, 32'h02);
      bus.irq = 8'h22;
      set_in(0, 0, 0, 0, 0, 0, 0);
      #1;
      check_val("prio_detect", bus.int_detect, 1);
      check_val("prio_id", bus.int_id, 1);
      cycle();
      set_in(1, 30'h70, 3'd3, 0, 0, 0, 0);
      #1;
      check_val("prio_pc", 32'(bus.new_pc), 32'h100);
      cycle();
      rd_chk("prio_cause", 5'd5, 32'h103);
      rd_chk("prio_pend", 5'd7, 32'h22);
      bus.irq = 8'h00;
      set_in(1, 30'h100, 0, 1, 0, 0, 0); cycle();

      // Masked edge pulse, then W1C.
      wr_cr(30'h500, 5'd6, 32'hFF);
      wr_cr(30'h501, 5'd8, 32'h01);
      bus.irq = 8'h01;
      idle();
      bus.irq = 8'h00;
      set_in(0, 0, 0, 0, 0, 0, 0);
      bus.creg_rd_addr = 5'd7;
      #1;
      check_val("mask_pend", bus.creg_rd_data, 32'h01);
      check_val("mask_detect", bus.int_detect, 0);
      cycle();
      set_in(1, 30'h80, 0, 0, 1, 5'd7, 32'h01);
      #1;
      check_val("w1c_flush", bus.flush, 1);
      check_val("w1c_pc", 32'(bus.new_pc), 32'h81);
      cycle();
      rd_chk("w1c_pend", 5'd7, 32'h0);

      // Asynchronous reset in the middle of a handler.
      wr_cr(30'h600, 5'd6, 32'h0F);
      set_in(1, 30'h90, 3'd4, 0, 0, 0, 0); cycle();
      wr_cr(30'h601, 5'd0, 32'h01);
      check_val("pre_rst_exe", bus.exe_mode, 1);
      reset = 1'b1;
      #1;
      check_val("arst_exe", bus.exe_mode, 0);
      bus.creg_rd_addr = 5'd9; #1;
      check_val("arst_lvl", bus.creg_rd_data, 0);
      bus.creg_rd_addr = 5'd6; #1;
      check_val("arst_mask", bus.creg_rd_data, 32'hFF);
      bus.creg_rd_addr = 5'd3; #1;
      check_val("arst_epc", bus.creg_rd_data, 0);
      m_reset();
      @(negedge clk);
      reset = 1'b0;

      // Randomized commits against the model.
      for (int n = 0; n < 1500; n++) begin
         bit [4:0] addrs[10];
         bit [31:0] d;
         addrs = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd12};
         for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) bus.irq[i] = ~bus.irq[i];
         bus.commit_en = ($urandom_range(0, 9) < 6);
         bus.commit_pc = 30'($urandom);
         bus.exc_code  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         bus.exrt      = ($urandom_range(0, 6) == 0);
         bus.wrcr      = ($urandom_range(0, 3) == 0);
         bus.cr_addr   = addrs[$urandom_range(0, 9)];
         d = $urandom;
         if (bus.cr_addr == 5'd0 && $urandom_range(0, 1) == 1) d[1] = 1'b1;
         bus.cr_wdata     = d;
         bus.creg_rd_addr = 5'($urandom_range(0, 15));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
